sp_mem_ctrl: RTL and testbench
==============================

// Module: sp_mem_ctrl
// PURPOSE
//   Parametrised single-port synchronous RAM with a req/ready request handshake,
//   byte-lane write enables and a fixed-latency read-valid strobe.
//   Optional post-reset clear sequencer zeroes every word before accepting requests.
//   Replaces the fixed 16-bit x 1K single-port memory in the top-level fabric.
//   Data-in and data-out are separate buses; there are no bidirectional data pins.
// PARAMETERS
//   DATA_W          16  word width in bits; must be a multiple of 8
//   ADDR_W          10  address width; depth = 2**ADDR_W words
//   RD_LAT           1  read latency in cycles; legal values are 1 or 2 (2 adds an output register)
//   CLEAR_ON_RESET   1  1 = zero all words after reset; 0 = contents undefined
// PORTS
//   clk        in   1         single clock; all logic on the rising edge
//   reset      in   1         synchronous, active-high
//   req        in   1         request valid
//   ready      out  1         controller can accept a request this cycle
//   we         in   1         1 = write, 0 = read (sampled with req)
//   addr       in   ADDR_W    word address
//   be         in   DATA_W/8  byte enables; be[i] covers wdata[8i+7:8i]
//   wdata      in   DATA_W    write data
//   rd_valid   out  1         rdata is valid this cycle (one-cycle pulse per read)
//   rdata      out  DATA_W    read data
//   clr_done   out  1         clear sequence finished; stays high until the next reset
// BEHAVIOUR
//   Reset, while reset=1, at every edge:
//     - ready=0, rd_valid=0, rdata=0, clr_done=0.
//     - Read pipeline flushed; the clear address counter is set to 0.
//   FSM states:
//     - CLEAR: ready=0. Writes 0 (all lanes) to address clr_addr, then clr_addr++.
//       After the write to 2**ADDR_W-1, moves to RUN and sets clr_done=1 on the same edge.
//       A clear of a full memory takes 2**ADDR_W cycles.
//     - RUN: ready=1 every cycle. Single port, so at most one access per cycle.
//   Reset exit:
//     - First cycle after reset drops enters CLEAR if CLEAR_ON_RESET=1.
//     - Otherwise it enters RUN, with ready=1 and clr_done=1 in that cycle.
//   Accept: a request is accepted when req & ready at a rising edge. req while ready=0 is ignored.
//     The requester must hold req until it sees ready; no request is queued.
//   Write: lanes with be[i]=1 are updated at the accept edge; lanes with be[i]=0 keep their value.
//     A write with be=0 is accepted but changes nothing.
//   Read: rd_valid=1 exactly RD_LAT cycles after the accept edge, with rdata = memory word at addr.
//     rdata holds its last value while rd_valid=0.
//   Back-to-back reads, one per cycle, give rd_valid high on consecutive cycles, in order.
//   Write-then-read of the same address on the next cycle returns the newly written data.
//     No forwarding is needed: the write completes at its own edge.
//   No write-data passthrough: a write never asserts rd_valid.
//   Address wrap: none needed, because depth is a power of two and every addr is in range.
//   Reset mid-operation:
//     - In-flight reads are discarded; no rd_valid appears after reset.
//     - A clear in progress restarts from address 0.
// TESTING
//   T1 DATA_W=16, ADDR_W=4, CLEAR_ON_RESET=1: release reset -> ready=0 for 16 cycles,
//      then ready=1 and clr_done=1; reads of addr 0..15 all return 16'h0000.
//   T2 Write 16'hBEEF to addr 3 (be=2'b11), then write 16'h12xx with be=2'b10,
//      then read addr 3 -> rdata=16'h12EF, rd_valid exactly RD_LAT cycles after the read accept.
//   T3 RD_LAT=2: read addr 1,2,3 on consecutive cycles -> three consecutive rd_valid pulses
//      starting 2 cycles after the first accept, data in address order.
//   T4 req=1 held during CLEAR -> no write occurs (memory is still 0 afterwards);
//      the request is accepted on the first RUN cycle.
//   T5 Issue a read, then assert reset on the next edge -> rd_valid never rises.
//      Clear restarts: ready stays 0 for 2**ADDR_W cycles after reset drops.
//   T6 CLEAR_ON_RESET=0: ready=1 and clr_done=1 on the first cycle after reset.
//      Write then read of addr 2**ADDR_W-1 round-trips correctly.

Source files
------------

// File: rtl/sp_mem_if.sv
// ---------------------------------------------------------------------------
// sp_mem_if
//   Request/response bundle between a requester and the single-port memory
//   controller.
//   master : drives req, we, addr, be, wdata; observes ready, rd_valid, rdata,
//            clr_done.
//   slave  : the memory controller side (directions mirrored).
// ---------------------------------------------------------------------------
interface sp_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                  req;
    logic                  ready;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rdata;
    logic                  clr_done;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rd_valid, rdata, clr_done
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rd_valid, rdata, clr_done
    );
endinterface

// File: rtl/sp_mem_ctrl.sv
// ---------------------------------------------------------------------------
// sp_mem_ctrl
//   Single-port synchronous RAM behind a req/ready handshake, with byte-lane
//   write enables and a fixed-latency (1 or 2 cycle) read-valid strobe.
//   An optional clear sequencer zeroes every word after reset before the
//   controller starts accepting requests.
// Ports
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : sp_mem_if slave modport
//            req/we/addr/be/wdata in; ready/rd_valid/rdata/clr_done out
// ---------------------------------------------------------------------------
module sp_mem_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic      clk,
    input  logic      reset,
    sp_mem_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               clr_en;
    logic [ADDR_W-1:0]  clr_addr;
    logic               run;
    logic               accept;
    logic               wr_en;
    logic               rd_en;
    logic               clr_go;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               rd_v1;
    logic [DATA_W-1:0]  rd_q1;
    logic               out_v;
    logic [DATA_W-1:0]  out_q;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (clr_en)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        clr_en    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (clr_addr == '1)
                    state_nxt = ST_RUN;
            end
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Outputs are forced low combinationally while reset is high, so even a
    // read strobe already sitting in the pipeline never shows during reset.
    assign run          = (state == ST_RUN) && !reset;
    assign bus.ready    = run;
    assign bus.clr_done = run;

    assign accept = bus.req && run;
    assign wr_en  = accept && bus.we;
    assign rd_en  = accept && !bus.we;
    assign clr_go = clr_en && !reset;

    // ------------------------------------------------------------- memory
    // NOTE: the array itself is not reset so it maps onto block RAM; the
    // clear sequencer provides zeroing when it is wanted.
    always_ff @(posedge clk) begin
        if (clr_go) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i])
                    mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------ read pipeline
    // Data registers only load on a new read, so rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v1 <= 1'b0;
            rd_q1 <= '0;
        end else begin
            rd_v1 <= rd_en;
            if (rd_en)
                rd_q1 <= mem[bus.addr];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              rd_v2;
            logic [DATA_W-1:0] rd_q2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_v2 <= 1'b0;
                    rd_q2 <= '0;
                end else begin
                    rd_v2 <= rd_v1;
                    if (rd_v1)
                        rd_q2 <= rd_q1;
                end
            end

            assign out_v = rd_v2;
            assign out_q = rd_q2;
        end else begin : g_lat1
            assign out_v = rd_v1;
            assign out_q = rd_q1;
        end
    endgenerate

    assign bus.rd_valid = out_v && !reset;
    assign bus.rdata    = reset ? '0 : out_q;

endmodule

// File: tb/tb_sp_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_mem_ctrl
//   Two controllers share one stimulus stream:
//     dut_a : 16x16, RD_LAT=2, CLEAR_ON_RESET=1
//     dut_b : 16x16, RD_LAT=1, CLEAR_ON_RESET=0
//   A behavioural model (word arrays plus a queue of pending read results)
//   predicts ready/clr_done/rd_valid/rdata; a negedge process compares both
//   DUTs every cycle. Directed steps add literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sp_mem_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [DW-1:0] wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sp_mem_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
    sp_mem_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

    assign if_a.req = req;  assign if_a.we = we;  assign if_a.addr = addr;
    assign if_a.be  = be;   assign if_a.wdata = wdata;
    assign if_b.req = req;  assign if_b.we = we;  assign if_b.addr = addr;
    assign if_b.be  = be;   assign if_b.wdata = wdata;

    sp_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    sp_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RESET(0)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic bit clears(int d);
        return d == 0;
    endfunction

    typedef struct {
        int            dut;
        int            due;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
    } rd_t;

    int            edge_cnt = 0;
    int            run_cnt  = 0;
    logic [DW-1:0] mm [2][DEPTH];
    logic [DW-1:0] kn [2][DEPTH];
    rd_t           pq [$];
    logic [DW-1:0] last_data [2];
    logic [DW-1:0] last_mask [2];

    // Ready once reset is low and (if clearing) DEPTH clean edges have passed.
    function automatic bit ready_exp(int d);
        return !reset && (!clears(d) || run_cnt >= DEPTH);
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            last_data[d] = '0;
            last_mask[d] = '1;
            for (int a = 0; a < DEPTH; a++) begin
                mm[d][a] = '0;
                kn[d][a] = '0;
            end
        end
    end

    always @(posedge clk) begin
        edge_cnt++;
        if (reset) begin
            run_cnt = 0;
            pq.delete();
            for (int d = 0; d < 2; d++) begin
                last_data[d] = '0;
                last_mask[d] = '1;
            end
            for (int a = 0; a < DEPTH; a++) kn[1][a] = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (req && ready_exp(d)) begin
                    if (we) begin
                        for (int i = 0; i < 2; i++) begin
                            if (be[i]) begin
                                mm[d][addr][8*i +: 8] = wdata[8*i +: 8];
                                kn[d][addr][8*i +: 8] = 8'hFF;
                            end
                        end
                    end else begin
                        pq.push_back('{d, edge_cnt + lat_of(d) - 1, mm[d][addr], kn[d][addr]});
                    end
                end
            end
            run_cnt++;
            if (run_cnt == DEPTH) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mm[0][a] = '0;
                    kn[0][a] = '1;
                end
            end
        end
    end

    // ----------------------------------------------------------- compare
    int            seen_cnt  [2] = '{0, 0};
    int            seen_edge [2] = '{0, 0};
    logic [DW-1:0] seen_data [2];
    int            lo_cnt    [2] = '{0, 0};

    always @(negedge clk) begin
        logic          rdy;
        logic          done;
        logic          vld;
        logic [DW-1:0] rd;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] msk;
        int            idx;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                rdy = if_a.ready; done = if_a.clr_done; vld = if_a.rd_valid; rd = if_a.rdata;
            end else begin
                rdy = if_b.ready; done = if_b.clr_done; vld = if_b.rd_valid; rd = if_b.rdata;
            end
            check($sformatf("ready_%0d", d), rdy, ready_exp(d));
            check($sformatf("clr_done_%0d", d), done, ready_exp(d));

            exp_v = 1'b0;
            if (!reset) begin
                idx = -1;
                for (int i = 0; i < pq.size(); i++) begin
                    if (pq[i].dut == d) begin
                        idx = i;
                        break;
                    end
                end
                if (idx >= 0 && pq[idx].due == edge_cnt) begin
                    exp_v        = 1'b1;
                    last_data[d] = pq[idx].data;
                    last_mask[d] = pq[idx].mask;
                    pq.delete(idx);
                end
            end
            check($sformatf("rd_valid_%0d", d), vld, exp_v);

            exp_d = reset ? '0 : last_data[d];
            msk   = reset ? '1 : last_mask[d];
            check($sformatf("rdata_%0d", d), rd & msk, exp_d & msk);

            if (vld) begin
                seen_cnt[d]++;
                seen_data[d] = rd;
                seen_edge[d] = edge_cnt;
            end
            if (reset)      lo_cnt[d] = 0;
            else if (!rdy)  lo_cnt[d]++;
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic drive(bit w, int a, logic [DW-1:0] d, logic [1:0] b);
        req   = 1'b1;
        we    = w;
        addr  = AW'(a);
        wdata = d;
        be    = b;
    endtask

    task automatic write1(int a, logic [DW-1:0] d, logic [1:0] b);
        drive(1'b1, a, d, b);
        tick();
        idle();
    endtask

    // One isolated read on both DUTs with literal data and latency checks.
    task automatic read_lit(string nm, int a, logic [DW-1:0] e0, logic [DW-1:0] e1, bit chk_b);
        int c0, c1, acc;
        c0 = seen_cnt[0];
        c1 = seen_cnt[1];
        drive(1'b0, a, '0, 2'b00);
        tick();
        acc = edge_cnt;
        idle();
        repeat (3) tick();
        check({nm, "_pulses_a"}, seen_cnt[0] - c0, 1);
        check({nm, "_pulses_b"}, seen_cnt[1] - c1, 1);
        check({nm, "_lat_a"}, seen_edge[0] - acc + 1, 2);
        check({nm, "_lat_b"}, seen_edge[1] - acc + 1, 1);
        check({nm, "_data_a"}, seen_data[0], e0);
        if (chk_b) check({nm, "_data_b"}, seen_data[1], e1);
    endtask

    task automatic random_phase(int n);
        for (int i = 0; i < n; i++) begin
            req   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            addr  = AW'($urandom_range(0, DEPTH - 1));
            be    = 2'($urandom_range(0, 3));
            wdata = DW'($urandom);
            tick();
        end
        idle();
        repeat (4) tick();
    endtask

    initial begin
        int k, c0, c1, acc;
        reset = 1'b1;
        idle();
        addr  = '0;
        wdata = '0;
        be    = '0;
        repeat (3) tick();
        check("rst_rdata_a", if_a.rdata, 16'h0000);
        check("rst_ready_b", if_b.ready, 1'b0);
        reset = 1'b0;

        // Requests held during the clear: a must ignore them, b accepts.
        drive(1'b1, 5, 16'hAAAA, 2'b11);
        repeat (8) tick();
        drive(1'b0, 7, '0, 2'b00);
        k = 0;
        while (!if_a.ready && k < 40) begin
            tick();
            k++;
        end
        check("t4_ready_seen", if_a.ready, 1'b1);
        c0 = seen_cnt[0];
        tick();
        acc = edge_cnt;
        idle();
        repeat (3) tick();
        check("t1_clear_len_a", lo_cnt[0], 16);
        check("t6_clear_len_b", lo_cnt[1], 0);
        check("t1_clr_done_a", if_a.clr_done, 1'b1);
        check("t4_first_run_pulses", seen_cnt[0] - c0, 1);
        check("t4_first_run_lat", seen_edge[0] - acc + 1, 2);
        check("t4_first_run_data", seen_data[0], 16'h0000);
        read_lit("t4_addr5", 5, 16'h0000, 16'hAAAA, 1'b1);

        // Back-to-back reads of every address.
        c0 = seen_cnt[0];
        c1 = seen_cnt[1];
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, a, '0, 2'b00);
            tick();
        end
        idle();
        repeat (3) tick();
        check("t1_sweep_pulses_a", seen_cnt[0] - c0, 16);
        check("t1_sweep_pulses_b", seen_cnt[1] - c1, 16);
        check("t1_sweep_last_a", seen_data[0], 16'h0000);

        // Byte-lane merge.
        write1(3, 16'hBEEF, 2'b11);
        write1(3, 16'h12A5, 2'b10);
        read_lit("t2", 3, 16'h12EF, 16'h12EF, 1'b1);

        // Three consecutive reads; the model checks order and spacing.
        write1(1, 16'h1111, 2'b11);
        write1(2, 16'h2222, 2'b11);
        write1(3, 16'h3333, 2'b11);
        c0 = seen_cnt[0];
        for (int a = 1; a <= 3; a++) begin
            drive(1'b0, a, '0, 2'b00);
            tick();
        end
        idle();
        repeat (3) tick();
        check("t3_pulses_a", seen_cnt[0] - c0, 3);
        check("t3_last_a", seen_data[0], 16'h3333);

        // Top address round trip, then a be=0 write that must change nothing.
        write1(15, 16'hC0DE, 2'b11);
        read_lit("t6", 15, 16'hC0DE, 16'hC0DE, 1'b1);
        write1(15, 16'hFFFF, 2'b00);
        read_lit("be0", 15, 16'hC0DE, 16'hC0DE, 1'b1);

        random_phase(400);

        // Reset right after a read accept: no pulse may follow, clear restarts.
        drive(1'b0, 3, '0, 2'b00);
        tick();
        reset = 1'b1;
        idle();
        c0 = seen_cnt[0];
        c1 = seen_cnt[1];
        repeat (4) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("t5_no_pulse_a", seen_cnt[0] - c0, 0);
        check("t5_no_pulse_b", seen_cnt[1] - c1, 0);
        check("t5_clear_len_a", lo_cnt[0], 16);
        check("t5_clear_len_b", lo_cnt[1], 0);

        random_phase(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
